id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register of the PYGMY-V32I core; sits directly downstream of the register file.
- Drives the register file read pointers, collects rs1/rs2 read data, and applies operand forwarding from EX and MEM.
- Detects load-use hazards and stalls decode for one cycle.
- Registers the resolved operands and control into a valid/ready-handshaked EX slot.

Parameters:
- XLEN, 32, datapath width.
- ALU_OP_W, 4, width of the ALU opcode field.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  decode offers an instruction.
- ready_o  out  1  stage accepts decode instruction this cycle.
- rs1_ptr_i, rs2_ptr_i, rd_ptr_i  in  5 each  decoded register indices.
- uses_rs1_i, uses_rs2_i  in  1 each  instruction reads rs1/rs2.
- reg_write_i, is_load_i  in  1 each  instruction writes rd / is a load.
- alu_op_i  in  ALU_OP_W  ALU opcode.
- imm_i, pc_i  in  XLEN each  immediate, PC.
- rf_rs1_ptr_o, rf_rs2_ptr_o  out  5 each  to register file; combinational copy of rs1_ptr_i/rs2_ptr_i.
- rf_rs1_i, rf_rs2_i  in  XLEN each  register file read data (combinational).
- ex_result_i  in  XLEN  ALU result of the instruction currently in the EX slot (combinational).
- mem_valid_i, mem_reg_write_i  in  1 each  MEM-stage instruction valid / writes rd.
- mem_rd_ptr_i  in  5  MEM-stage rd.
- mem_result_i  in  XLEN  final MEM result, load data included.
- flush_i  in  1  kill EX slot and incoming instruction (branch redirect).
- valid_o  out  1  EX slot holds an instruction.
- ready_i  in  1  EX consumes the slot.
- op_a_o, op_b_o  out  XLEN each  resolved rs1/rs2 values.
- rd_ptr_o, reg_write_o, is_load_o, alu_op_o, imm_o, pc_o  out  registered copies.
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst_ni low, async): valid_o=0; all registered outputs=0; stall_cnt_o=0.
- The EX slot is the output register. The slot is "occupied" when valid_o=1.
- Hazard:
  - hz = valid_o & is_load_o & reg_write_o & (rd_ptr_o!=0) & valid_i & ((uses_rs1_i & rs1_ptr_i==rd_ptr_o) | (uses_rs2_i & rs2_ptr_i==rd_ptr_o)).
- Handshake:
  - ready_o = (~valid_o | ready_i) & ~hz & ~flush_i.
  - Accept = valid_i & ready_o.
- Operand select, per source s in {rs1, rs2}, first match wins:
  1. ptr==0 gives 0.
  2. valid_o & reg_write_o & ~is_load_o & rd_ptr_o==ptr gives ex_result_i.
  3. mem_valid_i & mem_reg_write_i & mem_rd_ptr_i==ptr gives mem_result_i.
  4. Otherwise the register file value.
- No WB forwarding: the register file writes on negedge, so a WB write is readable at the next posedge.
- Update at posedge, in priority order:
  1. flush_i: valid_o<=0.
  2. Accept: load the slot with the resolved operands and fields; valid_o<=1. EX handing off in the same cycle is legal; that is the back-to-back case with 1-cycle throughput.
  3. ready_i & valid_o, no accept: valid_o<=0.
  4. Otherwise hold every output unchanged.
- Payload outputs are don't-care when valid_o=0 but must not toggle while valid_o=1 and ready_i=0.
- Latency: one cycle from accept to valid_o.
- Load-use: exactly one bubble. Next cycle the load has moved to MEM and is forwarded via mem_result_i.
- stall_cnt_o increments by 1 each cycle hz=1 & ~flush_i; saturates at all-ones.
- Flush while hz: the hazard is irrelevant, the slot is cleared, and nothing is accepted that cycle.
- Reset mid-operation: the slot is cleared immediately. No partial instruction survives.

Test Plan:
- Reset, then valid_i=1, rs1=5 (rf=0x11), rs2=6 (rf=0x22), ready_i=1 -> next cycle valid_o=1, op_a_o=0x11, op_b_o=0x22.
- Back-to-back: addi x3 then add x4,x3,x3 with ex_result_i=0x40 -> second instruction op_a_o=op_b_o=0x40; ready_o held 1; no bubble.
- Load-use: lw x7 in slot (is_load) and next uses rs1=7 -> ready_o=0 for one cycle, stall_cnt_o=1. Following cycle mem_rd_ptr_i=7, mem_result_i=0xDEAD -> op_a_o=0xDEAD.
- Priority: EX rd=9 result 0xA, MEM rd=9 result 0xB, rf x9=0xC -> op_a_o=0xA. Same case with EX idle -> 0xB. rs1=0 with all sources writing x0 -> op_a_o=0.
- Backpressure: ready_i=0 with slot full -> ready_o=0 and outputs frozen for 3 cycles; ready_i=1 releases the held instruction and accepts the waiting one in the same cycle.
- Flush: flush_i=1 with slot full and valid_i=1 -> next cycle valid_o=0, no accept. Assert rst_ni=0 mid-stall -> valid_o=0 and stall_cnt_o=0 immediately.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundle of every signal between the ID/EX operand stage and its neighbours:
// the decode offer, register file read port, EX/MEM forwarding taps, the
// flush line and the EX slot handshake/payload. Signal names keep the
// stage-relative _i/_o direction suffix.
//   slave  : the operand stage's view (consumes decode, drives the EX slot)
//   master : the surrounding pipeline's view (decode, RF, EX, MEM, redirect)
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
);
    // Decode side
    logic                valid_i;
    logic                ready_o;
    logic [4:0]          rs1_ptr_i;
    logic [4:0]          rs2_ptr_i;
    logic [4:0]          rd_ptr_i;
    logic                uses_rs1_i;
    logic                uses_rs2_i;
    logic                reg_write_i;
    logic                is_load_i;
    logic [ALU_OP_W-1:0] alu_op_i;
    logic [XLEN-1:0]     imm_i;
    logic [XLEN-1:0]     pc_i;
    // Register file read port
    logic [4:0]          rf_rs1_ptr_o;
    logic [4:0]          rf_rs2_ptr_o;
    logic [XLEN-1:0]     rf_rs1_i;
    logic [XLEN-1:0]     rf_rs2_i;
    // Forwarding taps and redirect
    logic [XLEN-1:0]     ex_result_i;
    logic                mem_valid_i;
    logic                mem_reg_write_i;
    logic [4:0]          mem_rd_ptr_i;
    logic [XLEN-1:0]     mem_result_i;
    logic                flush_i;
    // EX slot
    logic                valid_o;
    logic                ready_i;
    logic [XLEN-1:0]     op_a_o;
    logic [XLEN-1:0]     op_b_o;
    logic [4:0]          rd_ptr_o;
    logic                reg_write_o;
    logic                is_load_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [XLEN-1:0]     imm_o;
    logic [XLEN-1:0]     pc_o;
    logic [CNT_W-1:0]    stall_cnt_o;

    modport slave (
        input  valid_i, rs1_ptr_i, rs2_ptr_i, rd_ptr_i, uses_rs1_i, uses_rs2_i,
               reg_write_i, is_load_i, alu_op_i, imm_i, pc_i,
               rf_rs1_i, rf_rs2_i, ex_result_i, mem_valid_i, mem_reg_write_i,
               mem_rd_ptr_i, mem_result_i, flush_i, ready_i,
        output ready_o, rf_rs1_ptr_o, rf_rs2_ptr_o, valid_o, op_a_o, op_b_o,
               rd_ptr_o, reg_write_o, is_load_o, alu_op_o, imm_o, pc_o,
               stall_cnt_o
    );

    modport master (
        output valid_i, rs1_ptr_i, rs2_ptr_i, rd_ptr_i, uses_rs1_i, uses_rs2_i,
               reg_write_i, is_load_i, alu_op_i, imm_i, pc_i,
               rf_rs1_i, rf_rs2_i, ex_result_i, mem_valid_i, mem_reg_write_i,
               mem_rd_ptr_i, mem_result_i, flush_i, ready_i,
        input  ready_o, rf_rs1_ptr_o, rf_rs2_ptr_o, valid_o, op_a_o, op_b_o,
               rd_ptr_o, reg_write_o, is_load_o, alu_op_o, imm_o, pc_o,
               stall_cnt_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// Decode-to-execute pipeline register of the PYGMY-V32I core. Reads rs1/rs2
// from the register file, forwards from EX (non-load results) and MEM, inserts
// a single bubble on a load-use hazard, and holds the resolved instruction in
// a valid/ready EX slot.
// Ports:
//   clk_i  : clock, all state on posedge
//   rst_ni : asynchronous active-low reset
//   bus    : id_ex_operand_stage_if.slave (decode, RF, forwarding, EX slot)
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    id_ex_operand_stage_if.slave bus
);

    logic                r_valid;
    logic [XLEN-1:0]     r_op_a;
    logic [XLEN-1:0]     r_op_b;
    logic [4:0]          r_rd_ptr;
    logic                r_reg_write;
    logic                r_is_load;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic [XLEN-1:0]     r_imm;
    logic [XLEN-1:0]     r_pc;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_hz;
    logic                w_ready;
    logic                w_accept;
    logic                w_ex_fwd_ok;
    logic                w_mem_fwd_ok;
    logic [XLEN-1:0]     w_op_a;
    logic [XLEN-1:0]     w_op_b;

    // First match wins: x0, then EX, then MEM, then the register file.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      ptr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_val,
        input logic            mem_ok,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_val
    );
        if (ptr == 5'd0)                  return '0;
        else if (ex_ok && ex_rd == ptr)   return ex_val;
        else if (mem_ok && mem_rd == ptr) return mem_val;
        else                              return rf_val;
    endfunction

    assign bus.rf_rs1_ptr_o = bus.rs1_ptr_i;
    assign bus.rf_rs2_ptr_o = bus.rs2_ptr_i;

    // A load in the slot has no data yet, so it is never an EX forwarding
    // source; that case is exactly the load-use hazard below.
    assign w_ex_fwd_ok  = r_valid & r_reg_write & ~r_is_load;
    assign w_mem_fwd_ok = bus.mem_valid_i & bus.mem_reg_write_i;

    assign w_hz = r_valid & r_is_load & r_reg_write & (r_rd_ptr != 5'd0) & bus.valid_i &
                  ((bus.uses_rs1_i & (bus.rs1_ptr_i == r_rd_ptr)) |
                   (bus.uses_rs2_i & (bus.rs2_ptr_i == r_rd_ptr)));

    assign w_ready  = (~r_valid | bus.ready_i) & ~w_hz & ~bus.flush_i;
    assign w_accept = bus.valid_i & w_ready;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_op_a = resolve(bus.rs1_ptr_i, bus.rf_rs1_i, w_ex_fwd_ok, r_rd_ptr, bus.ex_result_i,
                         w_mem_fwd_ok, bus.mem_rd_ptr_i, bus.mem_result_i);
        w_op_b = resolve(bus.rs2_ptr_i, bus.rf_rs2_i, w_ex_fwd_ok, r_rd_ptr, bus.ex_result_i,
                         w_mem_fwd_ok, bus.mem_rd_ptr_i, bus.mem_result_i);
    end

    // NOTE: the payload is reset along with valid so reset leaves every output at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rd_ptr    <= '0;
            r_reg_write <= 1'b0;
            r_is_load   <= 1'b0;
            r_alu_op    <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (bus.flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid     <= 1'b1;
                r_op_a      <= w_op_a;
                r_op_b      <= w_op_b;
                r_rd_ptr    <= bus.rd_ptr_i;
                r_reg_write <= bus.reg_write_i;
                r_is_load   <= bus.is_load_i;
                r_alu_op    <= bus.alu_op_i;
                r_imm       <= bus.imm_i;
                r_pc        <= bus.pc_i;
            end else if (bus.ready_i && r_valid) begin
                r_valid <= 1'b0;
            end

            if (w_hz && !bus.flush_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.ready_o     = w_ready;
    assign bus.valid_o     = r_valid;
    assign bus.op_a_o      = r_op_a;
    assign bus.op_b_o      = r_op_b;
    assign bus.rd_ptr_o    = r_rd_ptr;
    assign bus.reg_write_o = r_reg_write;
    assign bus.is_load_o   = r_is_load;
    assign bus.alu_op_o    = r_alu_op;
    assign bus.imm_o       = r_imm;
    assign bus.pc_o        = r_pc;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Directed bench for id_ex_operand_stage: reset, basic issue, back-to-back
// forwarding, load-use bubble, forwarding priority, backpressure, flush and
// asynchronous reset mid-stall. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int CNT_W    = 32;

    logic clk_i = 1'b0;
    logic rst_ni;

    int n_checks = 0;
    int n_errors = 0;

    logic [XLEN-1:0] rf_mem [32];

    id_ex_operand_stage_if #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) bus ();

    id_ex_operand_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Combinational register file model
    assign bus.rf_rs1_i = rf_mem[bus.rf_rs1_ptr_o];
    assign bus.rf_rs2_i = rf_mem[bus.rf_rs2_ptr_o];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic ld, input logic [31:0] pc);
        bus.valid_i     = v;
        bus.rs1_ptr_i   = rs1;
        bus.rs2_ptr_i   = rs2;
        bus.rd_ptr_i    = rd;
        bus.uses_rs1_i  = u1;
        bus.uses_rs2_i  = u2;
        bus.reg_write_i = rw;
        bus.is_load_i   = ld;
        bus.alu_op_i    = pc[5:2];
        bus.imm_i       = pc + 32'h100;
        bus.pc_i        = pc;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] val);
        bus.mem_valid_i     = v;
        bus.mem_reg_write_i = v;
        bus.mem_rd_ptr_i    = rd;
        bus.mem_result_i    = val;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_mem(1'b0, 5'd0, 32'h0);
        bus.ex_result_i = '0;
        bus.flush_i     = 1'b0;
        bus.ready_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        n_checks++;
        if (bus.op_a_o !== 32'h0 || bus.pc_o !== 32'h0) begin
            n_errors++; $display("FAIL reset_payload: op_a %h pc %h want 0", bus.op_a_o, bus.pc_o);
        end
        n_checks++;
        if (bus.stall_cnt_o !== 32'h0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt_o); end
        n_checks++;
        if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rf_mem[5] = 32'h11;
        rf_mem[6] = 32'h22;
        issue(1'b1, 5'd5, 5'd6, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000);
        #1;
        n_checks++;
        if (bus.rf_rs1_ptr_o !== 5'd5 || bus.rf_rs2_ptr_o !== 5'd6) begin
            n_errors++; $display("FAIL basic_rf_ptr: got %0d/%0d want 5/6", bus.rf_rs1_ptr_o, bus.rf_rs2_ptr_o);
        end
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.op_a_o !== 32'h11 || bus.op_b_o !== 32'h22) begin
            n_errors++; $display("FAIL basic_ops: valid %b a %h b %h want 1 11 22", bus.valid_o, bus.op_a_o, bus.op_b_o);
        end
        n_checks++;
        if (bus.rd_ptr_o !== 5'd1 || bus.imm_o !== 32'h1100 || bus.pc_o !== 32'h1000 || bus.alu_op_o !== 4'h0) begin
            n_errors++; $display("FAIL basic_fields: rd %0d imm %h pc %h op %h", bus.rd_ptr_o, bus.imm_o, bus.pc_o, bus.alu_op_o);
        end
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_back_to_back();
        rf_mem[3] = 32'h99;
        issue(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000);
        tick();
        issue(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2004);
        bus.ex_result_i = 32'h40;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b want 1", bus.ready_o); end
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.op_a_o !== 32'h40 || bus.op_b_o !== 32'h40 || bus.pc_o !== 32'h2004) begin
            n_errors++; $display("FAIL b2b_fwd: valid %b a %h b %h pc %h want 1 40 40 2004", bus.valid_o, bus.op_a_o, bus.op_b_o, bus.pc_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        rf_mem[7] = 32'h777;
        issue(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3000);
        tick();
        issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3004);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0) begin n_errors++; $display("FAIL lu_stall_ready: got %b want 0", bus.ready_o); end
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd1) begin
            n_errors++; $display("FAIL lu_bubble: valid %b cnt %0d want 0 1", bus.valid_o, bus.stall_cnt_o);
        end
        set_mem(1'b1, 5'd7, 32'hDEAD);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL lu_release_ready: got %b want 1", bus.ready_o); end
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_mem(1'b0, 5'd0, 32'h0);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.op_a_o !== 32'hDEAD || bus.stall_cnt_o !== 32'd1) begin
            n_errors++; $display("FAIL lu_mem_fwd: valid %b a %h cnt %0d want 1 dead 1", bus.valid_o, bus.op_a_o, bus.stall_cnt_o);
        end
        tick();
    endtask

    task automatic test_priority();
        rf_mem[9] = 32'hC;
        rf_mem[0] = 32'h5A;
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000);
        tick();
        bus.ex_result_i = 32'hA;
        set_mem(1'b1, 5'd9, 32'hB);
        issue(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4004);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.op_a_o !== 32'hA) begin n_errors++; $display("FAIL prio_ex: got %h want a", bus.op_a_o); end
        tick();
        issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4008);
        tick();
        n_checks++;
        if (bus.op_a_o !== 32'hB) begin n_errors++; $display("FAIL prio_mem: got %h want b", bus.op_a_o); end
        // Slot now writes x0; MEM and the register file also target x0.
        set_mem(1'b1, 5'd0, 32'hB);
        issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h400C);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        set_mem(1'b0, 5'd0, 32'h0);
        n_checks++;
        if (bus.op_a_o !== 32'h0 || bus.op_b_o !== 32'h0) begin
            n_errors++; $display("FAIL prio_x0: a %h b %h want 0 0", bus.op_a_o, bus.op_b_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        issue(1'b1, 5'd5, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5000);
        tick();
        bus.ready_i = 1'b0;
        issue(1'b1, 5'd6, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5004);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_ready: got %b want 0", bus.ready_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h5000 || bus.op_a_o !== 32'h11 || bus.ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold%0d: valid %b pc %h a %h ready %b want 1 5000 11 0", i, bus.valid_o, bus.pc_o, bus.op_a_o, bus.ready_o);
            end
        end
        bus.ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b want 1", bus.ready_o); end
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h5004 || bus.op_a_o !== 32'h22) begin
            n_errors++; $display("FAIL bp_next: valid %b pc %h a %h want 1 5004 22", bus.valid_o, bus.pc_o, bus.op_a_o);
        end
        tick();
    endtask

    task automatic test_flush();
        issue(1'b1, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 32'h6000);
        tick();
        issue(1'b1, 5'd6, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 32'h6004);
        bus.flush_i = 1'b1;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", bus.ready_o); end
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_clear: got %b want 0", bus.valid_o); end
        // Flush during a load-use hazard: no stall is counted.
        bus.flush_i = 1'b0;
        issue(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h6008);
        tick();
        issue(1'b1, 5'd7, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600C);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd1) begin
            n_errors++; $display("FAIL flush_hz: valid %b cnt %0d want 0 1", bus.valid_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        issue(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7000);
        tick();
        bus.ready_i = 1'b0;
        issue(1'b1, 5'd0, 5'd8, 5'd17, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7004);
        tick();
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.stall_cnt_o !== 32'd3) begin
            n_errors++; $display("FAIL stall_accum: valid %b cnt %0d want 1 3", bus.valid_o, bus.stall_cnt_o);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.stall_cnt_o !== 32'd0 || bus.pc_o !== 32'h0) begin
            n_errors++; $display("FAIL async_reset: valid %b cnt %0d pc %h want 0 0 0", bus.valid_o, bus.stall_cnt_o, bus.pc_o);
        end
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
